// File: rtl/ddr3_wr_packer_if.sv
// ----------------------------------------------------------------------------
// ddr3_wr_packer_if
//
// Purpose:
//   Bundles the streaming input, the controller write port and the status
//   outputs of ddr3_wr_packer so they can be passed around as one object.
//
// Signals:
//   frame_start  - synchronous frame restart pulse (upstream -> packer)
//   din_valid    - input word valid                (upstream -> packer)
//   din          - input word, IN_WIDTH bits       (upstream -> packer)
//   din_ready    - packer can accept a word        (packer -> upstream)
//   flush        - pad and commit the partial beat (upstream -> packer)
//   ddr3_wr_req  - a full burst is stored          (packer -> controller)
//   ddr3_wr_ack  - controller consumes one beat    (controller -> packer)
//   ddr3_din     - beat data, OUT_WIDTH bits       (packer -> controller)
//   ddr3_wr_load - write-address reload pulse      (packer -> controller)
//   fifo_level   - beats currently stored          (status)
//   overflow     - sticky drop flag                (status)
//   underflow    - sticky empty-ack flag           (status)
//
// Modports:
//   master - the side that drives the stream and the acks
//   slave  - the packer itself
// ----------------------------------------------------------------------------
interface ddr3_wr_packer_if #(
   parameter int IN_WIDTH   = 16,
   parameter int OUT_WIDTH  = 128,
   parameter int FIFO_DEPTH = 32
);

   localparam int LEVEL_WIDTH = $clog2(FIFO_DEPTH) + 1;

   logic                   frame_start;
   logic                   din_valid;
   logic [IN_WIDTH-1:0]    din;
   logic                   din_ready;
   logic                   flush;
   logic                   ddr3_wr_req;
   logic                   ddr3_wr_ack;
   logic [OUT_WIDTH-1:0]   ddr3_din;
   logic                   ddr3_wr_load;
   logic [LEVEL_WIDTH-1:0] fifo_level;
   logic                   overflow;
   logic                   underflow;

   modport master (
      output frame_start,
      output din_valid,
      output din,
      output flush,
      output ddr3_wr_ack,
      input  din_ready,
      input  ddr3_wr_req,
      input  ddr3_din,
      input  ddr3_wr_load,
      input  fifo_level,
      input  overflow,
      input  underflow
   );

   modport slave (
      input  frame_start,
      input  din_valid,
      input  din,
      input  flush,
      input  ddr3_wr_ack,
      output din_ready,
      output ddr3_wr_req,
      output ddr3_din,
      output ddr3_wr_load,
      output fifo_level,
      output overflow,
      output underflow
   );

endinterface

// File: rtl/ddr3_wr_packer.sv
// ----------------------------------------------------------------------------
// ddr3_wr_packer
//
// Purpose:
//   Write-side feeder for the DDR3 burst controller. Packs IN_WIDTH-bit words
//   into OUT_WIDTH-bit beats (lane 0 in the LSBs), stores the beats in a
//   single-clock FIFO, requests a write once a full burst is stored and hands
//   one beat to the controller per ack, one clock after the ack so it lines up
//   with the controller's write enable.
//
// Ports:
//   clk_ref - the single clock
//   rst     - asynchronous active-high reset
//   bus     - ddr3_wr_packer_if slave modport carrying the input stream,
//             the controller write port and the status flags
//
// Parameters:
//   IN_WIDTH    - input word width
//   OUT_WIDTH   - beat width, a multiple of IN_WIDTH
//   BURST_BEATS - beats per controller burst
//   FIFO_DEPTH  - FIFO depth in beats, a power of two
// ----------------------------------------------------------------------------
module ddr3_wr_packer #(
   parameter int IN_WIDTH    = 16,
   parameter int OUT_WIDTH   = 128,
   parameter int BURST_BEATS = 8,
   parameter int FIFO_DEPTH  = 32
) (
   input logic             clk_ref,
   input logic             rst,
   ddr3_wr_packer_if.slave bus
);

   localparam int LANES       = OUT_WIDTH / IN_WIDTH;
   localparam int LANE_WIDTH  = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int PTR_WIDTH   = $clog2(FIFO_DEPTH);
   localparam int LEVEL_WIDTH = PTR_WIDTH + 1;

   localparam logic [LANE_WIDTH-1:0]  LAST_LANE  = LANE_WIDTH'(LANES - 1);
   localparam logic [LEVEL_WIDTH-1:0] FULL_LEVEL = LEVEL_WIDTH'(FIFO_DEPTH);
   localparam logic [LEVEL_WIDTH-1:0] BURST_LVL  = LEVEL_WIDTH'(BURST_BEATS);

   // Registered state
   logic [LANE_WIDTH-1:0]  lane;
   logic [OUT_WIDTH-1:0]   pack_reg;
   logic [PTR_WIDTH-1:0]   wr_ptr;
   logic [PTR_WIDTH-1:0]   rd_ptr;
   logic [LEVEL_WIDTH-1:0] level;
   logic [OUT_WIDTH-1:0]   dout;
   logic                   wr_req;
   logic                   wr_load;
   logic                   overflow;
   logic                   underflow;
   logic [OUT_WIDTH-1:0]   mem [FIFO_DEPTH];

   // Next-state / control
   logic                   ready;
   logic                   accept;
   logic                   commit;
   logic                   pop;
   logic                   push;
   logic                   drop;
   logic [OUT_WIDTH-1:0]   merged;
   logic [LANE_WIDTH-1:0]  lane_next;
   logic [OUT_WIDTH-1:0]   pack_next;
   logic [LEVEL_WIDTH-1:0] level_next;
   logic                   overflow_next;
   logic                   underflow_next;

   // Ready only blocks the word that would complete a beat while the FIFO is
   // full. It looks at registered state only, so a same-cycle ack does not
   // open it; the upstream side simply retries on the next cycle.
   always_comb begin
      ready = !((lane == LAST_LANE) && (level == FULL_LEVEL));
   end

   // Datapath and control for one clock. The pack register is cleared on
   // every commit, so its unfilled upper lanes are always zero and a flushed
   // beat needs no extra masking. frame_start overrides everything: the FIFO
   // empties, flags clear and an accepted word lands in lane 0 of the new
   // frame. A commit into a full FIFO is still taken when the head is popped
   // in the same cycle, since that pop frees the slot being written.
   always_comb begin
      accept         = bus.din_valid && ready;
      merged         = pack_reg;
      commit         = 1'b0;
      pop            = 1'b0;
      push           = 1'b0;
      drop           = 1'b0;
      lane_next      = lane;
      pack_next      = pack_reg;
      level_next     = level;
      overflow_next  = overflow;
      underflow_next = underflow;

      if (accept) begin
         merged[lane*IN_WIDTH +: IN_WIDTH] = bus.din;
      end

      if (bus.frame_start) begin
         lane_next      = '0;
         pack_next      = '0;
         level_next     = '0;
         overflow_next  = 1'b0;
         underflow_next = 1'b0;
         if (accept) begin
            lane_next                = LANE_WIDTH'(1);
            pack_next[IN_WIDTH-1:0]  = bus.din;
         end
      end else begin
         commit = (accept && (lane == LAST_LANE)) ||
                  (bus.flush && ((lane != '0) || accept));
         pop    = bus.ddr3_wr_ack && (level != '0);
         push   = commit && ((level != FULL_LEVEL) || pop);
         drop   = commit && !push;

         if (commit) begin
            lane_next = '0;
            pack_next = '0;
         end else if (accept) begin
            lane_next = lane + LANE_WIDTH'(1);
            pack_next = merged;
         end

         level_next     = level + LEVEL_WIDTH'(push) - LEVEL_WIDTH'(pop);
         overflow_next  = overflow || (bus.din_valid && !ready) || drop;
         underflow_next = underflow || (bus.ddr3_wr_ack && (level == '0));
      end
   end

   // Control registers. Reset and frame_start both land on the same empty
   // state; the request is computed from the next level so it is already
   // correct in the cycle the level changes.
   always_ff @(posedge clk_ref or posedge rst) begin
      if (rst) begin
         lane      <= '0;
         pack_reg  <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         dout      <= '0;
         wr_req    <= 1'b0;
         wr_load   <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         lane      <= lane_next;
         pack_reg  <= pack_next;
         level     <= level_next;
         overflow  <= overflow_next;
         underflow <= underflow_next;
         wr_load   <= bus.frame_start;
         wr_req    <= (level_next >= BURST_LVL);

         if (bus.frame_start) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PTR_WIDTH'(1);
               dout   <= mem[rd_ptr];
            end
         end
      end
   end

   // Beat storage. Contents need no reset; pointers decide what is valid.
   // The head is read in the pop cycle before this write lands, so a
   // simultaneous push into the slot being freed is safe.
   always_ff @(posedge clk_ref) begin
      if (push) begin
         mem[wr_ptr] <= merged;
      end
   end

   // Drive the interface from the registered state.
   assign bus.din_ready    = ready;
   assign bus.ddr3_wr_req  = wr_req;
   assign bus.ddr3_din     = dout;
   assign bus.ddr3_wr_load = wr_load;
   assign bus.fifo_level   = level;
   assign bus.overflow     = overflow;
   assign bus.underflow    = underflow;

endmodule
